demod_segment_window_ctrl: RTL and testbench
============================================

Name: demod_segment_window_ctrl

Overview:
- Parametrised successor to the fixed 10-segment demodulation segmenter with its hard-wired 3-cycle start counter.
- Accepts a qualified stream of DATA_W-bit demodulated words into a NUM_SEG-deep shift window and exposes all window taps in parallel.
- Generates start/valid/busy/done control from an explicit fill state machine with a configurable threshold and stop mode.
- Sits between the demodulator output and the segment-consuming decode stage in the modulation pipe.

Parameters:
- DATA_W, 32, width of each input word and each segment tap.
- NUM_SEG, 10, window depth, i.e. the number of segment taps; legal range 1..64.
- FILL_THRESH, 3, number of accepted words after start before valid asserts; legal range 1..NUM_SEG.
- CLEAR_ON_STOP, 0, 1 = window registers zeroed when start deasserts; 0 = window contents retained.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; high = window session active.
- in_valid  in  1  input_bit qualifier; a word is accepted only when start && in_valid.
- input_bit  in  DATA_W  demodulated input word.
- segments  out  NUM_SEG*DATA_W  flattened taps; segment k = bits [k*DATA_W +: DATA_W]; segment 0 = newest word.
- fill_count  out  $clog2(NUM_SEG+1)  words accepted this session, saturating at NUM_SEG.
- valid  out  1  window holds at least FILL_THRESH words of the current session.
- busy  out  1  exactly !valid.
- done  out  1  one-cycle pulse on the cycle valid first rises within a session.

Behaviour:
- Reset (synchronous, highest priority), values on the cycle after reset is sampled high:
  - segments = 0, fill_count = 0, valid = 0, busy = 1, done = 0, FSM in IDLE.
- Accept = start && in_valid. On accept, all in the same edge:
  - segment[0] <= input_bit.
  - segment[k] <= segment[k-1] for k = 1..NUM_SEG-1.
  - The oldest word is discarded.
- No accept: segments hold. Exception: the start-deassert clear described below.
- fill_count:
  - Increments on accept and saturates at NUM_SEG; further accepts still shift the window.
  - Clears to 0 on any cycle start is sampled low.
- FSM states: IDLE, FILL, FULL.
  - IDLE: start=0. valid=0. Goes to FILL when start=1.
  - FILL: counting accepts. Goes to FULL on the edge where the incremented fill_count equals FILL_THRESH. Goes to IDLE if start=0.
  - FULL: valid=1. Stays while start=1. Goes to IDLE when start=0.
  - If start=1 and accept occur together in IDLE, that word is accepted. FILL_THRESH=1 therefore goes IDLE->FULL in one edge.
- Registered outputs:
  - valid = (state==FULL), registered; rises on the edge that moves the FSM into FULL.
  - done is registered and high for exactly the first cycle valid is high in the session.
  - A new session requires start to drop for at least one cycle.
- start deasserted, taking effect on the next edge:
  - fill_count=0, valid=0, done=0, FSM to IDLE.
  - If CLEAR_ON_STOP=1, segments are zeroed on that same edge.
  - If CLEAR_ON_STOP=0, segments are retained.
- in_valid while start=0: ignored, no shift.
- Reset mid-session: identical to power-on reset regardless of start and in_valid.
- Compatibility: with in_valid tied high and FILL_THRESH=3, valid/busy timing is cycle-identical to the legacy 3-count controller, i.e. valid high on the 3rd edge with start high.
- Width rules:
  - fill_count compare is unsigned.
  - Counter width is $clog2(NUM_SEG+1). With NUM_SEG=1 it is 1 bit, and saturation must not wrap.

Decomposition:
- Shared package demod_pipe_pkg:
  - FSM state enum {IDLE, FILL, FULL}.
  - Function clog2-based count width.
  - Default DATA_W/NUM_SEG constants reused by the decode stage.
- One sub-module is natural: segment_shift_window (parametrised DATA_W/NUM_SEG register chain with shift enable and sync clear).
- The control FSM, counter and done pulse live in the top module.

Test Plan:
- Reset then start=1, in_valid=1, words 0x11,0x22,0x33 on consecutive cycles, defaults:
  - valid=0 after edges 1–2; valid=1, busy=0, done=1 after edge 3.
  - done=0 from edge 4.
  - segment0=0x33, segment1=0x22, segment2=0x11.
- start=1, in_valid toggling 1,0,1,0,1 with words A,–,B,–,C:
  - fill_count steps 1,1,2,2,3.
  - valid rises only after C; no shift on in_valid=0 cycles.
- Stream 12 words 1..12 with NUM_SEG=10:
  - segment0=12, segment9=3.
  - fill_count saturates at 10; valid stays 1; done pulses once.
- In FULL, drop start for 1 cycle then raise it:
  - valid=0 and fill_count=0 the next cycle.
  - CLEAR_ON_STOP=0: segments retained. CLEAR_ON_STOP=1: segments all 0.
  - A second done pulse occurs after 3 new accepts.
- Assert reset in FILL with fill_count=2 while start=1, in_valid=1:
  - Next cycle all outputs at reset values.
  - Deassert reset: counting restarts from 0.
- FILL_THRESH=1, NUM_SEG=1:
  - start and accept of 0xDEAD in the same cycle from IDLE gives valid=1, done=1 after one edge.
  - segment0=0xDEAD; fill_count stays 1 on further accepts.

Source files
------------

// File: rtl/demod_pipe_pkg.sv
// Shared types and constants for the demodulation segment pipeline.
// Used by the segment window controller and the downstream decode stage.
package demod_pipe_pkg;

    localparam int unsigned DEFAULT_DATA_W  = 32;
    localparam int unsigned DEFAULT_NUM_SEG = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } seg_state_e;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/segment_shift_window.sv
// NUM_SEG-deep register chain of DATA_W words; tap 0 holds the newest word.
// Synchronous clear has priority over shift.
module segment_shift_window #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SEG = 10
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic [DATA_W-1:0]         din,
    output logic [NUM_SEG*DATA_W-1:0] taps
);

    generate
        if (NUM_SEG == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (clear) begin
                    taps <= '0;
                end else if (shift_en) begin
                    taps <= din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (clear) begin
                    taps <= '0;
                end else if (shift_en) begin
                    taps <= {taps[(NUM_SEG-1)*DATA_W-1:0], din};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/demod_segment_window_ctrl.sv
// Segment window controller: qualified shift window plus fill FSM that
// generates start/valid/busy/done control for the decode stage.
module demod_segment_window_ctrl
    import demod_pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = DEFAULT_DATA_W,
    parameter int unsigned NUM_SEG       = DEFAULT_NUM_SEG,
    parameter int unsigned FILL_THRESH   = 3,
    parameter bit          CLEAR_ON_STOP = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                in_valid,
    input  logic [DATA_W-1:0]                   input_bit,
    output logic [NUM_SEG*DATA_W-1:0]           segments,
    output logic [count_width(NUM_SEG)-1:0]     fill_count,
    output logic                                valid,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned CNT_W = count_width(NUM_SEG);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(NUM_SEG);
    localparam logic [CNT_W:0]   THR = (CNT_W + 1)'(FILL_THRESH);

    seg_state_e       state, state_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   count_inc;
    logic             done_next;
    logic             accept;
    logic             win_clear;

    assign accept    = start && in_valid;
    assign win_clear = reset || (CLEAR_ON_STOP && !start);

    segment_shift_window #(
        .DATA_W  (DATA_W),
        .NUM_SEG (NUM_SEG)
    ) u_window (
        .clk      (clk),
        .clear    (win_clear),
        .shift_en (accept),
        .din      (input_bit),
        .taps     (segments)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fill_count <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            fill_count <= count_next;
            done       <= done_next;
        end
    end

    // One extra bit keeps the threshold compare free of wrap when NUM_SEG=1.
    assign count_inc = {1'b0, fill_count} + 1'b1;

    always_comb begin
        state_next = state;
        count_next = fill_count;
        done_next  = 1'b0;
        if (!start) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            if (accept && fill_count != SAT) begin
                count_next = count_inc[CNT_W-1:0];
            end
            case (state)
                IDLE, FILL: begin
                    state_next = FILL;
                    if (accept && count_inc == THR) begin
                        state_next = FULL;
                        done_next  = 1'b1;
                    end
                end
                FULL:    state_next = FULL;
                default: state_next = IDLE;
            endcase
        end
    end

    assign valid = (state == FULL);
    assign busy  = !valid;

endmodule

// File: tb/tb_demod_segment_window_ctrl.sv
// Directed self-checking bench for demod_segment_window_ctrl with default,
// clear-on-stop and single-segment/threshold-1 instances sharing one stimulus.
module tb_demod_segment_window_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 10;

    logic           clk = 1'b0;
    logic           reset, start, in_valid;
    logic [DW-1:0]  input_bit;

    logic [NS*DW-1:0] seg_a, seg_c;
    logic [3:0]       fc_a, fc_c;
    logic             val_a, busy_a, done_a, val_c, busy_c, done_c;
    logic [DW-1:0]    seg_o;
    logic [0:0]       fc_o;
    logic             val_o, busy_o, done_o;

    int tests = 0;
    int fails = 0;
    int done_pulses;

    always #5 clk = ~clk;

    demod_segment_window_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .input_bit(input_bit), .segments(seg_a), .fill_count(fc_a),
        .valid(val_a), .busy(busy_a), .done(done_a)
    );

    demod_segment_window_ctrl #(.CLEAR_ON_STOP(1'b1)) dut_c (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .input_bit(input_bit), .segments(seg_c), .fill_count(fc_c),
        .valid(val_c), .busy(busy_c), .done(done_c)
    );

    demod_segment_window_ctrl #(.NUM_SEG(1), .FILL_THRESH(1)) dut_o (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .input_bit(input_bit), .segments(seg_o), .fill_count(fc_o),
        .valid(val_o), .busy(busy_o), .done(done_o)
    );

    function automatic logic [DW-1:0] seg(input logic [NS*DW-1:0] v, input int unsigned k);
        return v[k*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
        reset = r; start = s; in_valid = v; input_bit = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; input_bit = '0;
        // Reset state
        step(1, 0, 0, 32'h0);
        chk("rst_seg", 64'(seg_a == '0), 64'd1);
        chk("rst_fc", 64'(fc_a), 64'd0);
        chk("rst_valid", 64'(val_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd1);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_one_busy", 64'(busy_o), 64'd1);

        // Legacy 3-count timing
        step(0, 1, 1, 32'h11);
        chk("leg_e1_valid", 64'(val_a), 64'd0);
        chk("leg_e1_fc", 64'(fc_a), 64'd1);
        step(0, 1, 1, 32'h22);
        chk("leg_e2_valid", 64'(val_a), 64'd0);
        step(0, 1, 1, 32'h33);
        chk("leg_e3_valid", 64'(val_a), 64'd1);
        chk("leg_e3_busy", 64'(busy_a), 64'd0);
        chk("leg_e3_done", 64'(done_a), 64'd1);
        chk("leg_seg0", 64'(seg(seg_a, 0)), 64'h33);
        chk("leg_seg1", 64'(seg(seg_a, 1)), 64'h22);
        chk("leg_seg2", 64'(seg(seg_a, 2)), 64'h11);
        chk("one_sat_fc", 64'(fc_o), 64'd1);
        chk("one_seg0", 64'(seg_o), 64'h33);
        step(0, 1, 0, 32'h99);
        chk("leg_e4_done", 64'(done_a), 64'd0);
        chk("leg_e4_valid", 64'(val_a), 64'd1);
        chk("leg_e4_hold", 64'(seg(seg_a, 0)), 64'h33);

        // Stop for one cycle (in_valid high must be ignored)
        step(0, 0, 1, 32'h77);
        chk("stop_valid", 64'(val_a), 64'd0);
        chk("stop_busy", 64'(busy_a), 64'd1);
        chk("stop_fc", 64'(fc_a), 64'd0);
        chk("stop_keep_seg0", 64'(seg(seg_a, 0)), 64'h33);
        chk("stop_keep_seg2", 64'(seg(seg_a, 2)), 64'h11);
        chk("stop_clr_seg", 64'(seg_c == '0), 64'd1);
        chk("stop_clr_fc", 64'(fc_c), 64'd0);
        chk("stop_one_seg", 64'(seg_o), 64'h33);

        // Gapped accepts: A,-,B,-,C
        step(0, 1, 1, 32'hA1);
        chk("gap_fc1", 64'(fc_a), 64'd1);
        step(0, 1, 0, 32'hFF);
        chk("gap_fc1b", 64'(fc_a), 64'd1);
        chk("gap_noshift", 64'(seg(seg_a, 0)), 64'hA1);
        step(0, 1, 1, 32'hB2);
        chk("gap_fc2", 64'(fc_a), 64'd2);
        step(0, 1, 0, 32'hFF);
        chk("gap_fc2b", 64'(fc_a), 64'd2);
        chk("gap_valid_lo", 64'(val_a), 64'd0);
        step(0, 1, 1, 32'hC3);
        chk("gap_fc3", 64'(fc_a), 64'd3);
        chk("gap_valid", 64'(val_a), 64'd1);
        chk("gap_done2", 64'(done_a), 64'd1);
        chk("gap_seg0", 64'(seg(seg_a, 0)), 64'hC3);
        chk("gap_seg1", 64'(seg(seg_a, 1)), 64'hB2);
        chk("gap_seg2", 64'(seg(seg_a, 2)), 64'hA1);
        chk("gap_seg3_keep", 64'(seg(seg_a, 3)), 64'h33);
        chk("gap_seg3_clr", 64'(seg(seg_c, 3)), 64'h0);
        chk("gap_clr_done", 64'(done_c), 64'd1);

        // Stream 1..12 into the 10-deep window
        step(0, 0, 0, 32'h0);
        done_pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, DW'(i));
            if (done_a) done_pulses++;
            chk("str_fc", 64'(fc_a), 64'((i > 10) ? 10 : i));
            chk("str_valid", 64'(val_a), 64'((i >= 3) ? 1 : 0));
        end
        chk("str_seg0", 64'(seg(seg_a, 0)), 64'd12);
        chk("str_seg9", 64'(seg(seg_a, 9)), 64'd3);
        chk("str_done_once", 64'(done_pulses), 64'd1);

        // Reset mid-FILL with start and in_valid held high
        step(0, 0, 0, 32'h0);
        step(0, 1, 1, 32'h5);
        step(0, 1, 1, 32'h6);
        chk("mid_fc2", 64'(fc_a), 64'd2);
        step(1, 1, 1, 32'h7);
        chk("mid_rst_seg", 64'(seg_a == '0), 64'd1);
        chk("mid_rst_fc", 64'(fc_a), 64'd0);
        chk("mid_rst_valid", 64'(val_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd1);
        chk("mid_rst_done", 64'(done_a), 64'd0);
        chk("mid_rst_one", 64'(seg_o), 64'h0);
        step(0, 1, 1, 32'h9);
        chk("mid_restart_fc", 64'(fc_a), 64'd1);
        chk("mid_restart_seg0", 64'(seg(seg_a, 0)), 64'h9);
        chk("mid_restart_seg1", 64'(seg(seg_a, 1)), 64'h0);

        // NUM_SEG=1, FILL_THRESH=1: IDLE->FULL in one edge
        step(0, 0, 0, 32'h0);
        chk("one_idle_valid", 64'(val_o), 64'd0);
        step(0, 1, 1, 32'hDEAD);
        chk("one_valid", 64'(val_o), 64'd1);
        chk("one_done", 64'(done_o), 64'd1);
        chk("one_seg", 64'(seg_o), 64'hDEAD);
        chk("one_fc", 64'(fc_o), 64'd1);
        step(0, 1, 1, 32'hBEEF);
        chk("one_fc_sat", 64'(fc_o), 64'd1);
        chk("one_seg2", 64'(seg_o), 64'hBEEF);
        chk("one_done_lo", 64'(done_o), 64'd0);
        chk("one_valid2", 64'(val_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
